// File: rtl/branch_predictor_gshare.sv
// Branch predictor: direct-mapped BTB plus a table of 2-bit saturating counters,
// indexed either by PC (bimodal) or by PC XOR global history (gshare).
module branch_predictor_gshare #(
  parameter int ENTRIES   = 16,
  parameter int HIST_BITS = 4,
  parameter int MODE      = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [31:0]          PC_current,
  output logic [31:0]          PCPredict,
  output logic                 prediction,
  output logic                 btbhit,
  input  logic [31:0]          PC,
  input  logic [31:0]          PCBranch,
  input  logic                 Branch,
  input  logic                 BranchTaken,
  output logic [1:0]           stateout,
  output logic [HIST_BITS-1:0] ghr
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic [ENTRIES-1:0]   valid;
  logic [TW-1:0]        tag_mem    [ENTRIES];
  logic [31:0]          target_mem [ENTRIES];
  logic [1:0]           pht        [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q;

  logic [IW-1:0] look_idx;
  logic [IW-1:0] look_pidx;
  logic [IW-1:0] upd_idx;
  logic [IW-1:0] upd_pidx;
  logic          unused_bits;

  function automatic logic [IW-1:0] idx_of(input logic [31:0] x);
    return x[IW+1:2];
  endfunction

  function automatic logic [TW-1:0] tag_of(input logic [31:0] x);
    return x[31:IW+2];
  endfunction

  function automatic logic [IW-1:0] pidx_of(input logic [31:0] x,
                                            input logic [HIST_BITS-1:0] h);
    logic [IW-1:0] hx;
    hx = IW'(h);
    return (MODE != 0) ? (idx_of(x) ^ hx) : idx_of(x);
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Truncating the concatenation drops the oldest bit; also covers HIST_BITS == 1.
  function automatic logic [HIST_BITS-1:0] ghr_shift(input logic [HIST_BITS-1:0] h,
                                                      input logic taken);
    return HIST_BITS'({h, taken});
  endfunction

  always_comb begin
    look_idx  = idx_of(PC_current);
    look_pidx = pidx_of(PC_current, ghr_q);
    upd_idx   = idx_of(PC);
    upd_pidx  = pidx_of(PC, ghr_q);
  end

  // Fetch-side lookup: asynchronous reads, so same-cycle updates are seen next cycle.
  assign btbhit      = valid[look_idx] && (tag_mem[look_idx] == tag_of(PC_current));
  assign PCPredict   = btbhit ? target_mem[look_idx] : 32'h0;
  assign prediction  = btbhit & pht[look_pidx][1];
  assign stateout    = Branch ? pht[upd_pidx] : 2'b00;
  assign ghr         = ghr_q;
  assign unused_bits = ^{PC[1:0], PC_current[1:0]};

  // Resolve-side training of control state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid <= '0;
      ghr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
    end else if (Branch) begin
      pht[upd_pidx] <= sat_step(pht[upd_pidx], BranchTaken);
      ghr_q         <= ghr_shift(ghr_q, BranchTaken);
      if (BranchTaken) valid[upd_idx] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset: a cleared valid bit masks stale contents.
  always_ff @(posedge Clk) begin
    if (Branch && BranchTaken) begin
      tag_mem[upd_idx]    <= tag_of(PC);
      target_mem[upd_idx] <= PCBranch;
    end
  end

endmodule
